keypad_encoder: RTL and testbench

// - Front-panel digit entry stage that sits directly upstream of the countdown timer.
// - Synchronises and debounces 10 raw digit keys (0-9) and encodes the pressed key to BCD.
// - Issues one active-low load strobe per accepted press; each strobe shifts the digit

---
 rtl/keypad_encoder.sv | 117 +++++++++++
 tb/tb_keypad_encoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Digit-entry front end: synchronises and debounces ten raw digit keys, encodes the
// accepted key to BCD and issues one active-low load strobe per press.
//
// state    | meaning
// IDLE     | panel released, waiting for a single clean key while entry is enabled
// DEBOUNCE | candidate key must stay unchanged for DEBOUNCE_CYCLES cycles
// LOAD     | one-cycle strobe; data holds the accepted digit
// RELEASE  | waiting for DEBOUNCE_CYCLES cycles of a fully released panel
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keys,
  input  logic       en,
  input  logic       digit_clr,
  output logic [3:0] data,
  output logic       loadn,
  output logic [1:0] digit_cnt,
  output logic       full
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] CNT_MAX = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, LOAD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [9:0]    sync1, ks;
  logic [9:0]    cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    data_nxt;
  logic          loadn_nxt;
  logic [1:0]    digit_cnt_nxt;
  logic          ks_valid;

  function automatic logic [3:0] bcd_of(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Exactly one key down; chords and an empty panel are never a press.
  assign ks_valid = (ks != 10'd0) && ((ks & (ks - 10'd1)) == 10'd0);
  assign full     = (digit_cnt == CNT_MAX);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      sync1     <= '0;
      ks        <= '0;
      cand      <= '0;
      cnt       <= '0;
      data      <= 4'd0;
      loadn     <= 1'b1;
      digit_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      sync1     <= keys;
      ks        <= sync1;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      data      <= data_nxt;
      loadn     <= loadn_nxt;
      digit_cnt <= digit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (en && ks_valid && !full) begin
          state_nxt = DEBOUNCE;
          cand_nxt  = ks;
        end
      end
      DEBOUNCE: begin
        // Losing enable sends us to RELEASE so a key held across en returning never loads.
        if (!en)                  state_nxt = RELEASE;
        else if (ks != cand)      state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = LOAD;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      LOAD: state_nxt = RELEASE;
      RELEASE: begin
        if (ks != 10'd0)          cnt_nxt   = '0;
        else if (cnt == CNT_LAST) state_nxt = IDLE;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_comb begin
    loadn_nxt     = (state_nxt != LOAD);
    data_nxt      = data;
    digit_cnt_nxt = digit_cnt;
    if (state_nxt == LOAD) data_nxt = bcd_of(cand);
    // A clear landing on the LOAD cycle still counts the digit being loaded.
    if (state == LOAD) begin
      if (digit_clr)                 digit_cnt_nxt = 2'd1;
      else if (digit_cnt != CNT_MAX) digit_cnt_nxt = digit_cnt + 2'd1;
    end else if (digit_clr) begin
      digit_cnt_nxt = 2'd0;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed panel scenarios plus random key traffic, every
// cycle compared against a press/release reference model.
module tb_keypad_encoder;
  localparam int DC = 4;
  localparam int MD = 3;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] keys = 10'd0;
  logic       en = 1'b1;
  logic       digit_clr = 1'b0;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_cnt;
  logic       full;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model state: synchroniser copies and press-tracking bookkeeping.
  logic [9:0] m_s1, m_ks, m_cand;
  int         m_run, m_quiet, m_cnt;
  bit         m_pend, m_rel, m_loadn;
  int         m_data;

  keypad_encoder #(.DEBOUNCE_CYCLES(DC), .MAX_DIGITS(MD)) dut (
    .clock(clock), .clrn(clrn), .keys(keys), .en(en), .digit_clr(digit_clr),
    .data(data), .loadn(loadn), .digit_cnt(digit_cnt), .full(full)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [9:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_ks = '0; m_cand = '0;
    m_run = 0; m_quiet = 0; m_cnt = 0;
    m_pend = 0; m_rel = 0; m_loadn = 1; m_data = 0;
  endtask

  // One rising edge: a press needs DC+1 consecutive identical one-hot samples to load,
  // then the panel must read empty for DC samples before the next press is looked at.
  task automatic model_edge();
    int  cnt_old;
    bit  ld_now;
    cnt_old = m_cnt;
    ld_now  = m_pend;
    m_loadn = 1;
    if (ld_now) m_cnt = digit_clr ? 1 : ((m_cnt < MD) ? m_cnt + 1 : m_cnt);
    else if (digit_clr) m_cnt = 0;

    if (ld_now) begin
      m_pend = 0; m_rel = 1; m_quiet = 0;
    end else if (m_rel) begin
      if (m_ks == 0) begin
        m_quiet++;
        if (m_quiet == DC) m_rel = 0;
      end else begin
        m_quiet = 0;
      end
    end else if (m_run > 0) begin
      if (!en) begin
        m_run = 0; m_rel = 1; m_quiet = 0;
      end else if (m_ks != m_cand) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DC + 1) begin
          m_run = 0; m_pend = 1; m_loadn = 0; m_data = key_index(m_cand);
        end
      end
    end else if (en && $countones(m_ks) == 1 && cnt_old < MD) begin
      m_run = 1; m_cand = m_ks;
    end
    m_ks = m_s1;
    m_s1 = keys;
  endtask

  task automatic step();
    @(posedge clock);
    if (clrn) model_edge();
    @(negedge clock);
    check_val("loadn", int'(loadn), int'(m_loadn));
    check_val("data", int'(data), m_data);
    check_val("digit_cnt", int'(digit_cnt), m_cnt);
    check_val("full", int'(full), (m_cnt == MD) ? 1 : 0);
    if (!loadn) pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int k, input int hold, input int rel);
    keys = 10'd1 << k;
    run(hold);
    keys = 10'd0;
    run(rel);
  endtask

  task automatic clear_digits();
    digit_clr = 1'b1;
    step();
    digit_clr = 1'b0;
  endtask

  initial begin
    int first_low;
    int kind, hold;
    logic [9:0] pat;
    model_reset();
    @(negedge clock);

    // Reset with key 5 already down.
    keys = 10'h020;
    clrn = 1'b0;
    model_reset();
    run(3);
    check_val("rst_data", int'(data), 0);
    check_val("rst_loadn", int'(loadn), 1);
    check_val("rst_cnt", int'(digit_cnt), 0);
    check_val("rst_full", int'(full), 0);
    clrn = 1'b1;
    pulses = 0;
    run(15);
    check_val("rst_key5_pulses", pulses, 1);
    check_val("rst_key5_data", int'(data), 5);
    keys = 10'd0;
    run(8);

    // Clean press of key 7 and its strobe latency.
    clear_digits();
    pulses = 0;
    first_low = -1;
    keys = 10'd1 << 7;
    for (int e = 0; e < 20; e++) begin
      step();
      if (!loadn && first_low < 0) first_low = e;
    end
    check_val("clean_edge", first_low, DC + 2);
    check_val("clean_pulses", pulses, 1);
    check_val("clean_data", int'(data), 7);
    check_val("clean_cnt", int'(digit_cnt), 1);
    keys = 10'd0;
    run(8);

    // Bouncing key 3.
    clear_digits();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      keys = ((i / 2) % 2 == 0) ? (10'd1 << 3) : 10'd0;
      step();
    end
    keys = 10'd1 << 3;
    run(15);
    check_val("bounce_pulses", pulses, 1);
    check_val("bounce_data", int'(data), 3);
    keys = 10'd0;
    run(8);

    // Two keys, then drop to one.
    pulses = 0;
    keys = 10'h006;
    run(15);
    check_val("chord_pulses", pulses, 0);
    keys = 10'h004;
    run(15);
    check_val("chord_drop_pulses", pulses, 1);
    check_val("chord_drop_data", int'(data), 2);
    keys = 10'd0;
    run(8);

    // Filling the field.
    clear_digits();
    pulses = 0;
    for (int k = 1; k <= 4; k++) press(k, 12, 8);
    check_val("full_pulses", pulses, 3);
    check_val("full_flag", int'(full), 1);
    check_val("full_data", int'(data), 3);
    clear_digits();
    pulses = 0;
    press(4, 12, 8);
    check_val("after_clr_pulses", pulses, 1);
    check_val("after_clr_data", int'(data), 4);
    check_val("after_clr_cnt", int'(digit_cnt), 1);

    // Enable dropped mid-debounce of key 9.
    clear_digits();
    pulses = 0;
    keys = 10'd1 << 9;
    run(4);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(20);
    check_val("en_held_pulses", pulses, 0);
    keys = 10'd0;
    run(8);
    press(9, 12, 8);
    check_val("en_repress_pulses", pulses, 1);
    check_val("en_repress_data", int'(data), 9);

    // Digit clear landing on the LOAD cycle (count was 1).
    keys = 10'd1 << 6;
    run(DC + 3);
    check_val("clr_on_load_strobe", int'(loadn), 0);
    digit_clr = 1'b1;
    step();
    digit_clr = 1'b0;
    check_val("clr_on_load_cnt", int'(digit_cnt), 1);
    keys = 10'd0;
    run(8);

    // Random traffic.
    for (int seg = 0; seg < 400; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 2)      pat = 10'd0;
      else if (kind <= 7) pat = 10'd1 << $urandom_range(0, 9);
      else if (kind == 8) pat = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
      else                pat = 10'($urandom_range(0, 1023));
      keys = pat;
      en = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        digit_clr = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 499) == 0) begin
          clrn = 1'b0;
          model_reset();
          step();
          clrn = 1'b1;
        end
        step();
      end
    end
    digit_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
